// File: rtl/elevator_ctrl_n.sv
// SCAN-scheduled elevator controller: latches car/hall requests, moves one floor
// per TRAVEL_CYC cycles, opens the door for DOOR_CYC cycles, and holds on stop.
module elevator_ctrl_n #(
    parameter int FLOORS     = 4,
    parameter int TRAVEL_CYC = 4,
    parameter int DOOR_CYC   = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [FLOORS-1:0]          intreq,
    input  logic [FLOORS-1:0]          extreq,
    input  logic                       stop,
    output logic [FLOORS-1:0]          open,
    output logic [$clog2(FLOORS)-1:0]  floor,
    output logic                       moving,
    output logic                       dir,
    output logic [FLOORS-1:0]          pending
);

    localparam int FW = $clog2(FLOORS);
    localparam int TW = (TRAVEL_CYC > 1) ? $clog2(TRAVEL_CYC) : 1;
    localparam int DW = (DOOR_CYC > 1) ? $clog2(DOOR_CYC) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_MOVE, ST_DOOR, ST_HALT} state_t;

    state_t             state_r;
    logic [TW-1:0]      travel_cnt_r;
    logic [DW-1:0]      door_cnt_r;

    logic [FLOORS-1:0]  req_s;
    logic [FW-1:0]      next_floor_s;
    logic               here_s;
    logic               above_s;
    logic               below_s;
    logic               nf_pend_s;
    logic               nf_ahead_s;
    logic               arrive_s;
    logic               door_done_s;

    function automatic logic any_above(input logic [FLOORS-1:0] p, input logic [FW-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < FLOORS; i++) r = r | (p[i] & (i > int'(f)));
        return r;
    endfunction

    function automatic logic any_below(input logic [FLOORS-1:0] p, input logic [FW-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < FLOORS; i++) r = r | (p[i] & (i < int'(f)));
        return r;
    endfunction

    function automatic logic [FLOORS-1:0] onehot(input logic [FW-1:0] f);
        return {{(FLOORS-1){1'b0}}, 1'b1} << f;
    endfunction

    // Next-floor and request-position decode; stepping is clamped to the shaft ends.
    always_comb begin
        req_s = intreq | extreq;
        if (dir && (floor != FW'(FLOORS-1))) begin
            next_floor_s = floor + 1'b1;
        end else if (!dir && (floor != '0)) begin
            next_floor_s = floor - 1'b1;
        end else begin
            next_floor_s = floor;
        end
        here_s      = pending[floor];
        above_s     = any_above(pending, floor);
        below_s     = any_below(pending, floor);
        nf_pend_s   = pending[next_floor_s];
        nf_ahead_s  = dir ? any_above(pending, next_floor_s) : any_below(pending, next_floor_s);
        arrive_s    = (travel_cnt_r == TW'(TRAVEL_CYC-1));
        door_done_s = (door_cnt_r == DW'(DOOR_CYC-1));
    end

    // Controller state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            floor        <= '0;
            dir          <= 1'b1;
            pending      <= '0;
            open         <= '0;
            moving       <= 1'b0;
            travel_cnt_r <= '0;
            door_cnt_r   <= '0;
        end else begin
            pending <= pending | req_s;
            case (state_r)
                ST_IDLE: begin
                    if (stop) begin
                        state_r <= ST_IDLE;
                    end else if (here_s) begin
                        state_r    <= ST_DOOR;
                        open       <= onehot(floor);
                        door_cnt_r <= '0;
                        pending    <= (pending | req_s) & ~onehot(floor);
                    end else if (dir ? above_s : below_s) begin
                        state_r      <= ST_MOVE;
                        moving       <= 1'b1;
                        travel_cnt_r <= '0;
                    end else if (dir ? below_s : above_s) begin
                        state_r      <= ST_MOVE;
                        moving       <= 1'b1;
                        dir          <= ~dir;
                        travel_cnt_r <= '0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                // Leaving HALT performs a normal travel step so a stop costs exactly its own length.
                ST_MOVE, ST_HALT: begin
                    if (stop) begin
                        state_r <= ST_HALT;
                        moving  <= 1'b0;
                    end else if (arrive_s) begin
                        floor        <= next_floor_s;
                        travel_cnt_r <= '0;
                        if (nf_pend_s) begin
                            state_r    <= ST_DOOR;
                            moving     <= 1'b0;
                            open       <= onehot(next_floor_s);
                            door_cnt_r <= '0;
                            pending    <= (pending | req_s) & ~onehot(next_floor_s);
                        end else if (nf_ahead_s) begin
                            state_r <= ST_MOVE;
                            moving  <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                            moving  <= 1'b0;
                        end
                    end else begin
                        state_r      <= ST_MOVE;
                        moving       <= 1'b1;
                        travel_cnt_r <= travel_cnt_r + 1'b1;
                    end
                end
                ST_DOOR: begin
                    pending <= (pending | req_s) & ~onehot(floor);
                    if (req_s[floor]) begin
                        door_cnt_r <= '0;
                    end else if (stop) begin
                        door_cnt_r <= door_cnt_r;
                    end else if (door_done_s) begin
                        state_r    <= ST_IDLE;
                        open       <= '0;
                        door_cnt_r <= '0;
                    end else begin
                        door_cnt_r <= door_cnt_r + 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    open    <= '0;
                    moving  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Directed bench: 4-floor instance for reset/latency/SCAN/stop/door-restart cases,
// 8-floor instance for the reversal scenario.
module tb_elevator_ctrl_n;

    logic       clk;
    logic       reset;
    logic [3:0] intreq4, extreq4, open4, pending4;
    logic       stop4, moving4, dir4;
    logic [1:0] floor4;
    logic [7:0] intreq8, extreq8, open8, pending8;
    logic       stop8, moving8, dir8;
    logic [2:0] floor8;

    int checks   = 0;
    int failures = 0;

    elevator_ctrl_n #(.FLOORS(4), .TRAVEL_CYC(4), .DOOR_CYC(3)) u4 (
        .clk(clk), .reset(reset), .intreq(intreq4), .extreq(extreq4), .stop(stop4),
        .open(open4), .floor(floor4), .moving(moving4), .dir(dir4), .pending(pending4)
    );

    elevator_ctrl_n #(.FLOORS(8), .TRAVEL_CYC(4), .DOOR_CYC(3)) u8 (
        .clk(clk), .reset(reset), .intreq(intreq8), .extreq(extreq8), .stop(stop8),
        .open(open8), .floor(floor8), .moving(moving8), .dir(dir8), .pending(pending8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        intreq4 = 4'h0; extreq4 = 4'h0; stop4 = 1'b0;
        intreq8 = 8'h00; extreq8 = 8'h00; stop8 = 1'b0;
        tick(2);
        chk("rst_open", open4, 32'h0);
        chk("rst_floor", floor4, 32'h0);
        chk("rst_pending", pending4, 32'h0);
        chk("rst_moving", moving4, 32'h0);
        chk("rst_dir", dir4, 32'h1);

        // reset while travelling
        reset = 1'b1;
        intreq4 = 4'b1000;
        tick(1);
        intreq4 = 4'h0;
        tick(3);
        chk("pre_rst_moving", moving4, 32'h1);
        reset = 1'b0;
        tick(2);
        chk("midrst_open", open4, 32'h0);
        chk("midrst_floor", floor4, 32'h0);
        chk("midrst_pending", pending4, 32'h0);
        chk("midrst_moving", moving4, 32'h0);
        chk("midrst_dir", dir4, 32'h1);
        reset = 1'b1;

        // floor 0 -> floor 3
        intreq4 = 4'b1000;
        tick(1);
        intreq4 = 4'h0;
        chk("f3_pending", pending4, 32'h8);
        chk("f3_idle_open", open4, 32'h0);
        tick(1);
        chk("f3_depart", moving4, 32'h1);
        tick(11);
        chk("f3_floor_k12", floor4, 32'h2);
        chk("f3_moving_k12", moving4, 32'h1);
        tick(1);
        chk("f3_floor", floor4, 32'h3);
        chk("f3_open", open4, 32'h8);
        chk("f3_stopped", moving4, 32'h0);
        chk("f3_cleared", pending4, 32'h0);
        tick(2);
        chk("f3_open_c3", open4, 32'h8);
        tick(1);
        chk("f3_closed", open4, 32'h0);

        // SCAN downward: floor 1 before floor 0
        extreq4 = 4'b0010;
        intreq4 = 4'b0001;
        tick(1);
        extreq4 = 4'h0;
        intreq4 = 4'h0;
        chk("dn_pending", pending4, 32'h3);
        tick(1);
        chk("dn_dir", dir4, 32'h0);
        tick(8);
        chk("dn_open1", open4, 32'h2);
        chk("dn_floor1", floor4, 32'h1);
        chk("dn_pend_left", pending4, 32'h1);
        tick(8);
        chk("dn_open0", open4, 32'h1);
        chk("dn_floor0", floor4, 32'h0);
        chk("dn_pend_none", pending4, 32'h0);
        tick(3);
        chk("dn_closed", open4, 32'h0);

        // stop for two cycles mid-move
        intreq4 = 4'b0100;
        tick(1);
        intreq4 = 4'h0;
        tick(2);
        chk("stop_pre_moving", moving4, 32'h1);
        stop4 = 1'b1;
        tick(1);
        chk("stop_moving_c1", moving4, 32'h0);
        tick(1);
        chk("stop_moving_c2", moving4, 32'h0);
        stop4 = 1'b0;
        tick(1);
        chk("stop_resume", moving4, 32'h1);
        tick(1);
        chk("stop_not_yet", floor4, 32'h0);
        tick(1);
        chk("stop_arrive1", floor4, 32'h1);
        tick(4);
        chk("stop_floor2", floor4, 32'h2);
        chk("stop_open2", open4, 32'h4);

        // door restart by a request for the current floor
        tick(1);
        intreq4 = 4'b0100;
        tick(1);
        intreq4 = 4'h0;
        chk("rst_door_open", open4, 32'h4);
        chk("rst_door_pend", pending4, 32'h0);
        tick(2);
        chk("rst_door_held", open4, 32'h4);
        tick(1);
        chk("rst_door_closed", open4, 32'h0);
        chk("rst_door_pend2", pending4, 32'h0);

        // idle latency: pending one edge, open the next
        intreq4 = 4'b0100;
        tick(1);
        intreq4 = 4'h0;
        chk("lat_pending", pending4, 32'h4);
        chk("lat_open_early", open4, 32'h0);
        tick(1);
        chk("lat_open", open4, 32'h4);
        tick(3);

        // 8 floors: serve 7 before reversing to 2
        intreq8 = 8'h80;
        tick(1);
        intreq8 = 8'h00;
        for (int i = 0; i < 100 && floor8 != 3'd5; i++) tick(1);
        chk("f8_reach5", floor8, 32'h5);
        intreq8 = 8'h04;
        tick(1);
        intreq8 = 8'h00;
        chk("f8_pending", pending8, 32'h84);
        chk("f8_dir_up", dir8, 32'h1);
        for (int i = 0; i < 100 && open8 == 8'h00; i++) tick(1);
        chk("f8_first_open", open8, 32'h80);
        chk("f8_first_floor", floor8, 32'h7);
        for (int i = 0; i < 100 && open8 != 8'h00; i++) tick(1);
        for (int i = 0; i < 100 && open8 == 8'h00; i++) tick(1);
        chk("f8_second_open", open8, 32'h04);
        chk("f8_second_floor", floor8, 32'h2);
        chk("f8_dir_down", dir8, 32'h0);
        chk("f8_pend_none", pending8, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/elevator_ctrl_n.md
ELEVATOR_CTRL_N -- requirements
Module: elevator_ctrl_n

Interface
REQ-001 Parameter FLOORS, default 4, number of served floors (legal 2..16).
REQ-002 Parameter TRAVEL_CYC, default 4, clock cycles to move one floor (legal >=1).
REQ-003 Parameter DOOR_CYC, default 3, clock cycles door stays open (legal >=1).
REQ-004 Port clk  in  1  single clock; all state changes on rising edge.
REQ-005 Port reset  in  1  synchronous, active-low reset; reset=0 at a rising edge resets all state.
REQ-006 Port intreq  in  FLOORS  car-panel buttons, bit i = floor i.
REQ-007 Port extreq  in  FLOORS  hall-call buttons, bit i = floor i.
REQ-008 Port stop  in  1  emergency hold, level-sensitive.
REQ-009 Port open  out  FLOORS  door-open, one-hot on current floor, else all zero.
REQ-010 Port floor  out  $clog2(FLOORS)  current floor index.
REQ-011 Port moving  out  1  car travelling between floors.
REQ-012 Port dir  out  1  direction of travel/preference, 1=up, 0=down.
REQ-013 Port pending  out  FLOORS  latched outstanding requests.

Function
REQ-014 Each edge: pending <= pending | intreq | extreq, minus the bit cleared by REQ-019; requests sticky until served, pulses of 1 cycle are sufficient.
REQ-015 States: IDLE, MOVE, DOOR, HALT; all outputs registered.
REQ-016 IDLE, stop=0: pending[floor]=1 -> DOOR; else pending bit ahead in dir -> MOVE keeping dir; else pending bit behind -> MOVE with dir inverted; else stay IDLE.
REQ-017 MOVE: travel counter increments each cycle; at count TRAVEL_CYC-1 floor steps +/-1 per dir and counter clears; moving=1 throughout MOVE.
REQ-018 On arrival at a floor with pending bit set -> DOOR; else pending ahead in dir -> remain MOVE; else -> IDLE (re-evaluates per REQ-016).
REQ-019 Entry to DOOR clears pending[floor]; a request for that floor arriving on the entry edge is absorbed, not latched.
REQ-020 DOOR: open[floor]=1 for DOOR_CYC cycles, then IDLE; new request for current floor during DOOR restarts door timer and is not latched.
REQ-021 stop=1 in MOVE -> HALT: travel counter frozen, moving=0, floor unchanged; stop=0 -> MOVE resuming frozen count.
REQ-022 stop=1 in DOOR: door held open, timer frozen; stop=1 in IDLE: no departure; requests still latch during stop.
REQ-023 floor never leaves 0..FLOORS-1; dir forced up at floor 0 and down at FLOORS-1 when departing.
REQ-024 Latency: request sampled at edge k sets pending; at floor in IDLE, open asserts after edge k+1.
REQ-025 Scheduling is SCAN: car serves all pending floors in current direction before reversing.

Reset
REQ-026 reset=0 at edge: state IDLE, floor=0, dir=1, pending=0, open=0, moving=0, travel and door counters 0; overrides stop and requests, including mid-move.
REQ-027 First edge with reset=1 behaves as IDLE with pending=0 plus that edge's requests.

Verification (FLOORS=4, TRAVEL_CYC=4, DOOR_CYC=3 unless noted)
REQ-028 reset=0 two edges mid-travel -> open=0000, floor=0, pending=0000, moving=0, dir=1.
REQ-029 From idle floor 0, intreq=1000 one cycle -> pending=1000, floor=3 after 12 MOVE cycles, open=1000 for 3 cycles, pending=0000.
REQ-030 At floor 3 idle, extreq=0010 and intreq=0001 same cycle -> dir=0, door opens at floor 1 (open=0010) before floor 0 (open=0001).
REQ-031 stop=1 for 2 cycles mid-MOVE -> moving=0 for those cycles, floor arrival delayed exactly 2 cycles.
REQ-032 In DOOR at floor 2, intreq=0100 on second door cycle -> open=0100 held 3 further cycles, pending stays 0000.
REQ-033 FLOORS=8: at floor 5 moving up, pending=10000100 -> floor 7 served first, then reverse, floor 2 served.
